mips_multicycle_ctrl: RTL and testbench

Multicycle control unit that sequences the shared MIPS datapath (single unified memory port, one ALU, register file, PC/IR registers) through fetch, decode, execute, memory and write-back steps. It decodes `op`/`funct` from the instruction register and drives every datapath enable and mux select. It stalls on a memory-ready handshake, handles `beq` via the ALU zero flag, and counts retired instructions. It sits beside the `processor` datapath and replaces its single-cycle control.

---
 rtl/mips_multicycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared datapath, stalls on mem_ready and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_ctl,
    output logic [3:0]          state,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;

    state_t                r_state;
    state_t                w_next;
    logic [RETIRE_W-1:0]   r_retired;
    logic                  w_retire;
    logic                  w_ir_write;
    logic                  w_pc_write;
    logic                  w_is_rtype;

    assign w_is_rtype = (op == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + RETIRE_W'(1);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        w_ir_write = 1'b0;
        w_pc_write = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctl    = 2'b00;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b01;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                // ALU computes PC + (imm << 2) now so BRANCH can use ALUOut.
                alu_src_b = 2'b11;
                if (w_is_rtype)                       w_next = S_EXECUTE;
                else if (op == OP_LW || op == OP_SW)  w_next = S_MEM_ADDR;
                else if (op == OP_BEQ)                w_next = S_BRANCH;
                else if (op == OP_J)                  w_next = S_JUMP;
                else begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_ctl   = (funct == FN_SUB) ? 2'b01 : 2'b00;
                w_next    = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctl    = 2'b01;
                pc_src     = 2'b01;
                w_pc_write = zero;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset holds FETCH, so only the register-load strobes need explicit gating.
    assign ir_write = w_ir_write & rst_n;
    assign pc_write = w_pc_write & rst_n;
    assign state    = r_state;
    assign retired  = r_retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class through
// the FSM and checks state, control outputs and the retired counter.
module tb_mips_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        i_or_d;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_ctl;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    mips_multicycle_ctrl #(.RETIRE_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctl(alu_ctl), .state(state), .illegal(illegal), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f);
        op    = o;
        funct = f;
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = 6'd0;
        funct     = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        step();
        step();

        // Reset values with mem_ready high
        check("rst_state", 32'(state), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_ir_write", 32'(ir_write), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd1);
        check("rst_alu_src_b", 32'(alu_src_b), 32'd1);

        rst_n = 1'b1;
        #1;
        check("fetch_ir_write", 32'(ir_write), 32'd1);
        check("fetch_pc_write", 32'(pc_write), 32'd1);

        // add: 0 -> 1 -> 6 -> 7 -> 0
        set_instr(6'b000000, 6'b100000);
        step();
        check("add_s1", 32'(state), 32'd1);
        check("dec_alu_src_b", 32'(alu_src_b), 32'd3);
        check("dec_illegal", 32'(illegal), 32'd0);
        check("dec_reg_write", 32'(reg_write), 32'd0);
        step();
        check("add_s6", 32'(state), 32'd6);
        check("add_alu_src_a", 32'(alu_src_a), 32'd1);
        check("add_alu_ctl", 32'(alu_ctl), 32'd0);
        check("add_exec_reg_write", 32'(reg_write), 32'd0);
        step();
        check("add_s7", 32'(state), 32'd7);
        check("add_reg_write", 32'(reg_write), 32'd1);
        check("add_reg_dst", 32'(reg_dst), 32'd1);
        check("add_mem_to_reg", 32'(mem_to_reg), 32'd0);
        check("add_ret_before", retired, 32'd0);
        step();
        check("add_s0", 32'(state), 32'd0);
        check("add_retired", retired, 32'd1);
        check("add_fetch_reg_write", 32'(reg_write), 32'd0);

        // sub
        set_instr(6'b000000, 6'b100010);
        step();
        step();
        check("sub_s6", 32'(state), 32'd6);
        check("sub_alu_ctl", 32'(alu_ctl), 32'd1);
        step();
        step();
        check("sub_retired", retired, 32'd2);

        // FETCH stall
        mem_ready = 1'b0;
        #1;
        check("fstall_ir_write", 32'(ir_write), 32'd0);
        step();
        check("fstall_state", 32'(state), 32'd0);
        check("fstall_mem_req", 32'(mem_req), 32'd1);
        mem_ready = 1'b1;

        // lw with two wait cycles in MEM_READ
        set_instr(6'b100011, 6'b000000);
        step();
        check("lw_s1", 32'(state), 32'd1);
        step();
        check("lw_s2", 32'(state), 32'd2);
        check("lw_alu_src_b", 32'(alu_src_b), 32'd2);
        check("lw_addr_mem_req", 32'(mem_req), 32'd0);
        mem_ready = 1'b0;
        step();
        check("lw_s3_c1", 32'(state), 32'd3);
        check("lw_mem_req", 32'(mem_req), 32'd1);
        check("lw_i_or_d", 32'(i_or_d), 32'd1);
        check("lw_mem_we", 32'(mem_we), 32'd0);
        step();
        check("lw_s3_c2", 32'(state), 32'd3);
        check("lw_wait_pc_write", 32'(pc_write), 32'd0);
        check("lw_wait_ir_write", 32'(ir_write), 32'd0);
        check("lw_wait_reg_write", 32'(reg_write), 32'd0);
        step();
        check("lw_s3_c3", 32'(state), 32'd3);
        check("lw_wait_i_or_d", 32'(i_or_d), 32'd1);
        mem_ready = 1'b1;
        step();
        check("lw_s4", 32'(state), 32'd4);
        check("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
        check("lw_reg_write", 32'(reg_write), 32'd1);
        check("lw_reg_dst", 32'(reg_dst), 32'd0);
        step();
        check("lw_s0", 32'(state), 32'd0);
        check("lw_retired", retired, 32'd3);

        // sw
        set_instr(6'b101011, 6'b000000);
        step();
        check("sw_dec_reg_write", 32'(reg_write), 32'd0);
        step();
        check("sw_s2", 32'(state), 32'd2);
        check("sw_addr_reg_write", 32'(reg_write), 32'd0);
        step();
        check("sw_s5", 32'(state), 32'd5);
        check("sw_mem_we", 32'(mem_we), 32'd1);
        check("sw_mem_req", 32'(mem_req), 32'd1);
        check("sw_i_or_d", 32'(i_or_d), 32'd1);
        check("sw_reg_write", 32'(reg_write), 32'd0);
        check("sw_ret_before", retired, 32'd3);
        step();
        check("sw_s0", 32'(state), 32'd0);
        check("sw_retired", retired, 32'd4);

        // beq taken
        set_instr(6'b000100, 6'b000000);
        zero = 1'b1;
        step();
        step();
        check("beqt_s8", 32'(state), 32'd8);
        check("beqt_pc_write", 32'(pc_write), 32'd1);
        check("beqt_pc_src", 32'(pc_src), 32'd1);
        check("beqt_alu_ctl", 32'(alu_ctl), 32'd1);
        step();
        check("beqt_retired", retired, 32'd5);

        // beq not taken
        zero = 1'b0;
        step();
        step();
        check("beqn_s8", 32'(state), 32'd8);
        check("beqn_pc_write", 32'(pc_write), 32'd0);
        step();
        check("beqn_s0", 32'(state), 32'd0);
        check("beqn_retired", retired, 32'd6);

        // j
        set_instr(6'b000010, 6'b000000);
        step();
        step();
        check("j_s9", 32'(state), 32'd9);
        check("j_pc_write", 32'(pc_write), 32'd1);
        check("j_pc_src", 32'(pc_src), 32'd2);
        step();
        check("j_retired", retired, 32'd7);

        // illegal opcode
        set_instr(6'b111111, 6'b000000);
        step();
        check("ill_s1", 32'(state), 32'd1);
        check("ill_pulse", 32'(illegal), 32'd1);
        step();
        check("ill_s0", 32'(state), 32'd0);
        check("ill_cleared", 32'(illegal), 32'd0);
        check("ill_retired", retired, 32'd7);

        // illegal funct on R-type
        set_instr(6'b000000, 6'b000000);
        step();
        check("illf_pulse", 32'(illegal), 32'd1);
        step();
        check("illf_s0", 32'(state), 32'd0);
        check("illf_retired", retired, 32'd7);

        // counter wrap
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        #1;
        check("wrap_preload", retired, 32'hFFFF_FFFF);
        set_instr(6'b000010, 6'b000000);
        step();
        step();
        step();
        check("wrap_s0", 32'(state), 32'd0);
        check("wrap_retired", retired, 32'd0);

        // reset in MEM_WRITE
        set_instr(6'b101011, 6'b000000);
        step();
        step();
        mem_ready = 1'b0;
        step();
        check("swr_s5", 32'(state), 32'd5);
        step();
        check("swr_hold", 32'(state), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("swr_state", 32'(state), 32'd0);
        check("swr_mem_we", 32'(mem_we), 32'd0);
        check("swr_retired", retired, 32'd0);
        mem_ready = 1'b1;
        step();
        check("swr_reg_write", 32'(reg_write), 32'd0);
        check("swr_pc_write", 32'(pc_write), 32'd0);
        rst_n = 1'b1;
        step();
        check("swr_after_s1", 32'(state), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
